// File: rtl/fft_frame_ctrl_pkg.sv
// Shared types and constants for the FFT frame sequencer.
package fft_frame_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_CFG      = 2'd1,
    ST_FEED     = 2'd2,
    ST_WAIT_OUT = 2'd3
  } state_t;

  localparam int ERR_ALM     = 0;
  localparam int ERR_WDOG    = 1;
  localparam int ERR_W       = 2;
  localparam int FRAME_CNT_W = 16;
  localparam int WDOG_W      = 16;
  localparam int ALM_W       = 3;

  function automatic int unsigned fft_len(input int unsigned logs_len);
    return 32'd1 << logs_len;
  endfunction

endpackage

// File: rtl/fft_frame_ctrl_if.sv
// Control, ADC sample, FFT config/data and status signals of the frame sequencer.
interface fft_frame_ctrl_if
  import fft_frame_ctrl_pkg::*;
#(
  parameter int INPUT_WIDTH  = 16,
  parameter int DATAIN_WIDTH = 16
);
  logic                      i_start;
  logic                      i_stop;
  logic                      i_continuous;
  logic                      i_fft_mode;
  logic                      i_smp_tvalid;
  logic [INPUT_WIDTH-1:0]    i_smp_tdata;
  logic                      o_smp_tready;
  logic                      o_fft_cfg_tvalid;
  logic                      o_fft_cfg_tdata;
  logic                      o_fft_data_tvalid;
  logic [2*DATAIN_WIDTH-1:0] o_fft_data_tdata;
  logic                      o_fft_data_tlast;
  logic                      i_fft_data_tready;
  logic                      i_fft_out_tvalid;
  logic                      i_fft_out_tlast;
  logic [ALM_W-1:0]          i_fft_alm;
  logic                      o_busy;
  logic                      o_frame_done;
  logic [FRAME_CNT_W-1:0]    o_frame_cnt;
  logic [ERR_W-1:0]          o_err;

  modport slave (
    input  i_start, i_stop, i_continuous, i_fft_mode,
    input  i_smp_tvalid, i_smp_tdata, i_fft_data_tready,
    input  i_fft_out_tvalid, i_fft_out_tlast, i_fft_alm,
    output o_smp_tready, o_fft_cfg_tvalid, o_fft_cfg_tdata,
    output o_fft_data_tvalid, o_fft_data_tdata, o_fft_data_tlast,
    output o_busy, o_frame_done, o_frame_cnt, o_err
  );

  modport master (
    output i_start, i_stop, i_continuous, i_fft_mode,
    output i_smp_tvalid, i_smp_tdata, i_fft_data_tready,
    output i_fft_out_tvalid, i_fft_out_tlast, i_fft_alm,
    input  o_smp_tready, o_fft_cfg_tvalid, o_fft_cfg_tdata,
    input  o_fft_data_tvalid, o_fft_data_tdata, o_fft_data_tlast,
    input  o_busy, o_frame_done, o_frame_cnt, o_err
  );

endinterface

// File: rtl/fft_wdog_timer.sv
// Cycle counter with clear/enable; expire is high during the WDOG_CYCLES-th enabled cycle.
module fft_wdog_timer
  import fft_frame_ctrl_pkg::*;
#(
  parameter int WDOG_CYCLES = 65535
) (
  input  logic clk,
  input  logic srst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam logic [WDOG_W-1:0] LIMIT = WDOG_W'(WDOG_CYCLES - 1);

  logic [WDOG_W-1:0] cnt_reg;

  always_ff @(posedge clk) begin
    if (srst || clr) begin
      cnt_reg <= '0;
    end else if (en) begin
      cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign expire = en && (cnt_reg == LIMIT);

endmodule

// File: rtl/fft_frame_ctrl.sv
// Frame sequencer: configures the FFT core, streams one frame of ADC samples into it,
// waits for the output frame and optionally re-arms, with watchdog and sticky alarms.
module fft_frame_ctrl
  import fft_frame_ctrl_pkg::*;
#(
  parameter int LOGS_FFT_LEN = 11,
  parameter int INPUT_WIDTH  = 16,
  parameter int DATAIN_WIDTH = 16,
  parameter int WDOG_CYCLES  = 65535
) (
  input logic            i_aclk,
  input logic            i_rst,
  fft_frame_ctrl_if.slave bus
);

  localparam int unsigned           FFT_LEN  = fft_len(LOGS_FFT_LEN);
  localparam logic [LOGS_FFT_LEN-1:0] LAST_IDX = LOGS_FFT_LEN'(FFT_LEN - 1);

  state_t                   state_reg;
  state_t                   state_next;
  logic [LOGS_FFT_LEN-1:0]  smp_cnt_reg;
  logic                     run_cont_reg;
  logic [ERR_W-1:0]         err_reg;
  logic [FRAME_CNT_W-1:0]   frame_cnt_reg;
  logic                     frame_done_reg;

  logic                     cfg_active;
  logic                     feed_active;
  logic                     wait_active;
  logic                     busy;
  logic                     xfer;
  logic                     last_xfer;
  logic                     completion;
  logic                     wdog_expire;
  logic                     timeout;
  logic signed [DATAIN_WIDTH-1:0] re_ext;

  fft_wdog_timer #(
    .WDOG_CYCLES(WDOG_CYCLES)
  ) u_wdog (
    .clk   (i_aclk),
    .srst  (i_rst),
    .clr   (!wait_active),
    .en    (wait_active),
    .expire(wdog_expire)
  );

  assign xfer       = feed_active && bus.i_smp_tvalid && bus.i_fft_data_tready;
  assign last_xfer  = xfer && (smp_cnt_reg == LAST_IDX);
  assign completion = wait_active && bus.i_fft_out_tvalid && bus.i_fft_out_tlast;
  // A completion landing on the expiry cycle wins over the timeout.
  assign timeout    = wdog_expire && !completion;

  always_ff @(posedge i_aclk) begin
    if (i_rst) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      ST_IDLE:     if (bus.i_start) state_next = ST_CFG;
      ST_CFG:      state_next = ST_FEED;
      ST_FEED:     if (last_xfer) state_next = ST_WAIT_OUT;
      ST_WAIT_OUT: begin
        if (completion) begin
          state_next = (run_cont_reg && !bus.i_stop) ? ST_CFG : ST_IDLE;
        end else if (timeout) begin
          state_next = ST_IDLE;
        end
      end
      default:     state_next = ST_IDLE;
    endcase
  end

  always_comb begin
    cfg_active  = 1'b0;
    feed_active = 1'b0;
    wait_active = 1'b0;
    busy        = 1'b1;
    case (state_reg)
      ST_IDLE:     busy        = 1'b0;
      ST_CFG:      cfg_active  = 1'b1;
      ST_FEED:     feed_active = 1'b1;
      ST_WAIT_OUT: wait_active = 1'b1;
      default:     busy        = 1'b0;
    endcase
  end

  always_ff @(posedge i_aclk) begin
    if (i_rst) begin
      smp_cnt_reg    <= '0;
      run_cont_reg   <= 1'b0;
      err_reg        <= '0;
      frame_cnt_reg  <= '0;
      frame_done_reg <= 1'b0;
    end else begin
      frame_done_reg <= completion;
      if (completion) begin
        frame_cnt_reg <= frame_cnt_reg + 1'b1;
      end
      if (cfg_active) begin
        smp_cnt_reg <= '0;
      end else if (xfer) begin
        smp_cnt_reg <= smp_cnt_reg + 1'b1;
      end
      if (!busy) begin
        if (bus.i_start) begin
          run_cont_reg <= bus.i_continuous;
          err_reg      <= '0;
        end
      end else begin
        if (bus.i_stop) run_cont_reg <= 1'b0;
        if (|bus.i_fft_alm) err_reg[ERR_ALM] <= 1'b1;
        if (timeout) err_reg[ERR_WDOG] <= 1'b1;
      end
    end
  end

  // Samples are carried in the real lane, sign-extended to the padded width.
  assign re_ext = DATAIN_WIDTH'(signed'(bus.i_smp_tdata));

  assign bus.o_fft_cfg_tvalid  = cfg_active;
  assign bus.o_fft_cfg_tdata   = cfg_active && bus.i_fft_mode;
  assign bus.o_fft_data_tvalid = feed_active && bus.i_smp_tvalid;
  assign bus.o_smp_tready      = feed_active && bus.i_fft_data_tready;
  assign bus.o_fft_data_tlast  = feed_active && (smp_cnt_reg == LAST_IDX);
  assign bus.o_fft_data_tdata  = feed_active ? {{DATAIN_WIDTH{1'b0}}, re_ext} : '0;
  assign bus.o_busy            = busy;
  assign bus.o_frame_done      = frame_done_reg;
  assign bus.o_frame_cnt       = frame_cnt_reg;
  assign bus.o_err             = err_reg;

endmodule

// File: tb/tb_fft_frame_ctrl.sv
// Scoreboard bench for fft_frame_ctrl: random samples/handshakes checked against frame-level expectations.
module tb_fft_frame_ctrl;

  localparam int LOGS = 3;
  localparam int N    = 1 << LOGS;
  localparam int IW   = 16;
  localparam int DW   = 16;
  localparam int WDOG = 20;

  typedef struct {
    logic [2*DW-1:0] data;
    logic            last;
  } beat_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_frame_ctrl_if #(.INPUT_WIDTH(IW), .DATAIN_WIDTH(DW)) bus ();

  fft_frame_ctrl #(
    .LOGS_FFT_LEN(LOGS),
    .INPUT_WIDTH (IW),
    .DATAIN_WIDTH(DW),
    .WDOG_CYCLES (WDOG)
  ) dut (
    .i_aclk(clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [IW-1:0] src_q[$];
  beat_t       exp_data[$];
  logic        exp_cfg[$];
  logic [15:0] exp_done[$];
  int          cfg_seen  = 0;
  int          xfer_seen = 0;
  int          last_seen = 0;
  logic        src_random    = 1'b0;
  logic        tready_toggle = 1'b0;
  logic        out_enable    = 1'b1;
  logic [15:0] model_frames  = '0;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endfunction

  function automatic void fail_now(string name, string why);
    n_checks++;
    n_fail++;
    $display("FAIL %s: %s", name, why);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Monitor: pops expectations whenever the DUT presents a config, data beat or frame_done.
  initial begin
    beat_t e;
    logic  prev_complete;
    prev_complete = 1'b0;
    forever begin
      @(negedge clk);
      if (bus.o_fft_cfg_tvalid === 1'b1) begin
        cfg_seen++;
        if (exp_cfg.size() == 0) fail_now("cfg_unexpected", "config strobe with none expected");
        else check("cfg_mode", bus.o_fft_cfg_tdata, exp_cfg.pop_front());
      end
      if (bus.o_fft_data_tvalid === 1'b1) begin
        check("tready_pass", bus.o_smp_tready, bus.i_fft_data_tready);
      end
      if (bus.o_fft_data_tvalid === 1'b1 && bus.i_fft_data_tready === 1'b1) begin
        xfer_seen++;
        if (bus.o_fft_data_tlast === 1'b1) last_seen++;
        if (exp_data.size() == 0) fail_now("data_unexpected", "data transfer with none expected");
        else begin
          e = exp_data.pop_front();
          check("data", bus.o_fft_data_tdata, e.data);
          check("data_tlast", bus.o_fft_data_tlast, e.last);
        end
      end
      if (bus.o_frame_done === 1'b1) begin
        check("done_latency", prev_complete, 1);
        if (exp_done.size() == 0) fail_now("done_unexpected", "frame_done with none expected");
        else check("frame_cnt_at_done", bus.o_frame_cnt, exp_done.pop_front());
      end
      prev_complete = bus.i_fft_out_tvalid && bus.i_fft_out_tlast;
    end
  end

  // ADC source: presents queued samples in order, advancing only on acceptance.
  initial begin
    logic acc;
    bus.i_smp_tvalid = 1'b0;
    bus.i_smp_tdata  = '0;
    forever begin
      @(negedge clk);
      acc = bus.i_smp_tvalid && bus.o_smp_tready;
      step();
      if (acc && src_q.size() > 0) void'(src_q.pop_front());
      if (src_q.size() > 0 && (!src_random || 1'($urandom_range(1, 0)))) begin
        bus.i_smp_tvalid = 1'b1;
        bus.i_smp_tdata  = src_q[0];
      end else begin
        bus.i_smp_tvalid = 1'b0;
      end
    end
  end

  // FFT input ready: constant or toggling every cycle.
  initial begin
    bus.i_fft_data_tready = 1'b1;
    forever begin
      step();
      bus.i_fft_data_tready = tready_toggle ? ~bus.i_fft_data_tready : 1'b1;
    end
  end

  // FFT output model: after each input frame, a few non-last beats then the last beat.
  initial begin
    int handled;
    int d;
    handled = 0;
    bus.i_fft_out_tvalid = 1'b0;
    bus.i_fft_out_tlast  = 1'b0;
    forever begin
      step();
      bus.i_fft_out_tvalid = 1'b0;
      bus.i_fft_out_tlast  = 1'b0;
      if (last_seen != handled) begin
        handled = last_seen;
        if (out_enable) begin
          d = $urandom_range(5, 0);
          repeat (d) begin
            bus.i_fft_out_tvalid = 1'($urandom_range(1, 0));
            step();
          end
          bus.i_fft_out_tvalid = 1'b1;
          bus.i_fft_out_tlast  = 1'b1;
          model_frames = model_frames + 16'd1;
          exp_done.push_back(model_frames);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "global timeout");
  end

  task automatic push_frame(input logic force_min);
    logic [IW-1:0]        s;
    logic signed [IW-1:0] ss;
    beat_t                b;
    for (int i = 0; i < N; i++) begin
      s  = (i == 0 && force_min) ? {1'b1, {(IW-1){1'b0}}} : IW'($urandom);
      ss = s;
      b.data = {{DW{1'b0}}, DW'(ss)};
      b.last = (i == N - 1);
      src_q.push_back(s);
      exp_data.push_back(b);
    end
  endtask

  task automatic start_run(input logic cont, input logic mode, input int frames);
    for (int i = 0; i < frames; i++) exp_cfg.push_back(mode);
    bus.i_continuous = cont;
    bus.i_fft_mode   = mode;
    bus.i_start      = 1'b1;
    step();
    bus.i_start      = 1'b0;
  endtask

  task automatic check_all_zero(string tag);
    check({tag, "_busy"},       bus.o_busy, 0);
    check({tag, "_cfg_tvalid"}, bus.o_fft_cfg_tvalid, 0);
    check({tag, "_tready"},     bus.o_smp_tready, 0);
    check({tag, "_tvalid"},     bus.o_fft_data_tvalid, 0);
    check({tag, "_tlast"},      bus.o_fft_data_tlast, 0);
    check({tag, "_tdata"},      bus.o_fft_data_tdata, 0);
    check({tag, "_done"},       bus.o_frame_done, 0);
    check({tag, "_frame_cnt"},  bus.o_frame_cnt, 0);
    check({tag, "_err"},        bus.o_err, 0);
  endtask

  task automatic flush();
    src_q.delete();
    exp_data.delete();
    exp_cfg.delete();
    exp_done.delete();
    model_frames = '0;
  endtask

  task automatic do_reset(string tag);
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    flush();
    @(negedge clk);
    check_all_zero(tag);
    step();
  endtask

  task automatic wait_idle(string name, int budget);
    logic done;
    done = 1'b0;
    for (int i = 0; i < budget && !done; i++) begin
      @(negedge clk);
      if (bus.o_busy === 1'b0) done = 1'b1;
    end
    if (!done) fail_now(name, "still busy at cycle budget");
    step();
  endtask

  task automatic check_drained(string tag);
    check({tag, "_data_left"}, exp_data.size(), 0);
    check({tag, "_cfg_left"},  exp_cfg.size(), 0);
    check({tag, "_done_left"}, exp_done.size(), 0);
  endtask

  initial begin
    int base;
    int cnt;
    logic seen;
    bus.i_start      = 1'b0;
    bus.i_stop       = 1'b0;
    bus.i_continuous = 1'b0;
    bus.i_fft_mode   = 1'b0;
    bus.i_fft_alm    = '0;

    // Single forward frame, ready always high, most-negative first sample.
    do_reset("rst0");
    push_frame(1'b1);
    start_run(1'b0, 1'b1, 1);
    @(negedge clk);
    check("cfg_at_n1", bus.o_fft_cfg_tvalid, 1);
    @(negedge clk);
    check("cfg_one_cycle", bus.o_fft_cfg_tvalid, 0);
    check("busy_in_feed", bus.o_busy, 1);
    wait_idle("single_idle", 200);
    check("single_frame_cnt", bus.o_frame_cnt, model_frames);
    check("single_err", bus.o_err, 0);
    check_drained("single");
    $display("single run: frames=%0d", bus.o_frame_cnt);

    // Backpressure: toggling ready and random valid.
    src_random    = 1'b1;
    tready_toggle = 1'b1;
    push_frame(1'b0);
    start_run(1'b0, 1'b0, 1);
    wait_idle("bp_idle", 400);
    check("bp_frame_cnt", bus.o_frame_cnt, model_frames);
    check_drained("bp");
    tready_toggle = 1'b0;
    $display("backpressure run: frames=%0d", bus.o_frame_cnt);

    // Continuous run, stopped during the third frame's FEED.
    do_reset("rst1");
    for (int f = 0; f < 3; f++) push_frame(1'b0);
    base = cfg_seen;
    start_run(1'b1, 1'b0, 3);
    seen = 1'b0;
    for (int i = 0; i < 600 && !seen; i++) begin
      if (cfg_seen >= base + 3) seen = 1'b1;
      else step();
    end
    if (!seen) fail_now("cont_cfg3", "third config strobe never seen");
    step();
    bus.i_stop = 1'b1;
    step();
    bus.i_stop = 1'b0;
    wait_idle("cont_idle", 400);
    check("cont_frame_cnt", bus.o_frame_cnt, 3);
    check("cont_cfg_count", cfg_seen - base, 3);
    check_drained("cont");
    src_random = 1'b0;
    $display("continuous run: frames=%0d cfg=%0d", bus.o_frame_cnt, cfg_seen - base);

    // Watchdog: no output tlast.
    do_reset("rst2");
    out_enable = 1'b0;
    push_frame(1'b0);
    base = last_seen;
    start_run(1'b0, 1'b1, 1);
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      if (last_seen != base) seen = 1'b1;
      else step();
    end
    if (!seen) fail_now("wdog_tlast", "input tlast never transferred");
    cnt  = 0;
    seen = 1'b0;
    for (int i = 0; i < 200 && !seen; i++) begin
      @(negedge clk);
      if (bus.o_busy === 1'b0) seen = 1'b1;
      else cnt++;
    end
    check("wdog_cycles", cnt, WDOG);
    check("wdog_err", bus.o_err, 2'b10);
    check("wdog_frame_cnt", bus.o_frame_cnt, 0);
    step();
    check_drained("wdog");
    out_enable = 1'b1;
    push_frame(1'b0);
    start_run(1'b0, 1'b1, 1);
    @(negedge clk);
    check("err_cleared", bus.o_err, 0);
    wait_idle("wdog_rerun_idle", 200);
    check("wdog_rerun_cnt", bus.o_frame_cnt, 1);
    check_drained("wdog_rerun");
    $display("watchdog run: wait cycles=%0d", cnt);

    // Reset at the 5th sample transfer.
    do_reset("rst3");
    push_frame(1'b0);
    base = xfer_seen;
    start_run(1'b0, 1'b0, 1);
    seen = 1'b0;
    for (int i = 0; i < 100 && !seen; i++) begin
      if (xfer_seen >= base + 4) seen = 1'b1;
      else step();
    end
    if (!seen) fail_now("midrst_xfer4", "four transfers never seen");
    rst = 1'b1;
    step();
    rst = 1'b0;
    flush();
    @(negedge clk);
    check_all_zero("midrst");
    step();
    push_frame(1'b0);
    start_run(1'b0, 1'b1, 1);
    wait_idle("midrst_idle", 200);
    check("midrst_frame_cnt", bus.o_frame_cnt, 1);
    check_drained("midrst");
    $display("mid-frame reset run: frames=%0d", bus.o_frame_cnt);

    // FFT alarm during FEED.
    do_reset("rst4");
    push_frame(1'b0);
    start_run(1'b0, 1'b1, 1);
    step();
    bus.i_fft_alm = 3'b001;
    step();
    bus.i_fft_alm = '0;
    wait_idle("alm_idle", 200);
    check("alm_err", bus.o_err, 2'b01);
    check("alm_frame_cnt", bus.o_frame_cnt, 1);
    check_drained("alm");
    $display("alarm run: err=%0b", bus.o_err);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
